ram_reader: RTL and testbench

RAM_READER -- requirements
Module: ram_reader

---
 rtl/rdmx_buf_pkg.sv | 21 ++
 rtl/rd_out_fifo.sv | 63 ++++++
 rtl/ram_reader.sv | 165 ++++++++++++++++
 tb/tb_ram_reader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdmx_buf_pkg.sv
// Shared definitions for the RAM readout path: parameter defaults, FSM state
// encoding and a counter-width helper.
package rdmx_buf_pkg;

   localparam int DATA_W_DEF     = 512;
   localparam int ADDR_W_DEF     = 12;
   localparam int RD_LAT_DEF     = 2;
   localparam int FIFO_DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } rd_state_e;

   // Bits needed to hold the values 0..n inclusive.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/rd_out_fifo.sv
// First-word-fall-through output buffer. The head entry is visible on
// o_pop_data whenever o_empty is low. A push into a full buffer or a pop
// from an empty one is ignored.
module rd_out_fifo
   import rdmx_buf_pkg::*;
#(
   parameter int WIDTH = DATA_W_DEF + 1,
   parameter int DEPTH = FIFO_DEPTH_DEF
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_push,
   input  logic [WIDTH-1:0]            i_push_data,
   input  logic                        i_pop,
   output logic [WIDTH-1:0]            o_pop_data,
   output logic                        o_empty,
   output logic [cnt_width(DEPTH)-1:0] o_count
);
   localparam int CNT_W = cnt_width(DEPTH);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push     = i_push && (r_count != CNT_W'(DEPTH));
   assign w_pop      = i_pop && (r_count != '0);
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;
   assign o_pop_data = r_mem[r_rd_ptr];

   // Storage write; contents need no reset because occupancy is tracked separately
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // Pointer and occupancy bookkeeping; push+pop together leave the count unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ram_reader.sv
// Reads a frame of beat_count words from a fixed-latency RAM starting at
// address 0 and streams them out on an AXI-Stream style port. Reads are only
// issued when the output buffer is guaranteed room for every word in flight,
// so backpressure can never overflow it.
module ram_reader
   import rdmx_buf_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int RD_LAT     = RD_LAT_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
)(
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [ADDR_W:0]   beat_count,
   output logic              idle,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] axis_tdata,
   output logic              axis_tvalid,
   output logic              axis_tlast,
   input  logic              axis_tready
);
   localparam int CNT_W = cnt_width(FIFO_DEPTH);

   logic              r_rst_meta;
   logic              r_rst_sync;
   logic              w_rst_n;
   rd_state_e         r_state;
   rd_state_e         w_state_next;
   logic [ADDR_W:0]   r_remaining;
   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_inflight;
   logic [RD_LAT-1:0] r_tag_valid;
   logic [RD_LAT-1:0] r_tag_last;
   logic [CNT_W:0]    w_occupancy;
   logic              w_space;
   logic              w_start_ok;
   logic              w_issue;
   logic              w_ret;
   logic              w_pop;
   logic [DATA_W:0]   w_fifo_dout;
   logic              w_fifo_empty;
   logic [CNT_W-1:0]  w_fifo_count;

   // Reset bridge: entry into reset is immediate, release is aligned to clk
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rst_meta <= 1'b0;
         r_rst_sync <= 1'b0;
      end else begin
         r_rst_meta <= 1'b1;
         r_rst_sync <= r_rst_meta;
      end
   end
   assign w_rst_n = r_rst_sync;

   assign w_start_ok  = (r_state == ST_IDLE) && start && (beat_count != '0);
   assign w_occupancy = {1'b0, w_fifo_count} + {1'b0, r_inflight};
   assign w_space     = (w_occupancy < (CNT_W + 1)'(FIFO_DEPTH));
   assign w_issue     = (r_state == ST_READ) && (r_remaining != '0) && w_space;
   assign w_ret       = r_tag_valid[RD_LAT-1];
   assign w_pop       = axis_tvalid && axis_tready;

   // FSM state register
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state; DRAIN exits on the cycle the final beat is accepted so idle
   // is already high in the following cycle
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_start_ok) begin
               w_state_next = ST_READ;
            end
         end
         ST_READ: begin
            if (w_issue && (r_remaining == (ADDR_W + 1)'(1))) begin
               w_state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((r_inflight == '0) && !w_ret &&
                (w_fifo_empty || ((w_fifo_count == CNT_W'(1)) && w_pop))) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Frame address and beats-left counter
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_addr      <= '0;
         r_remaining <= '0;
      end else if (w_start_ok) begin
         r_addr      <= '0;
         r_remaining <= beat_count;
      end else if (w_issue) begin
         r_addr      <= r_addr + ADDR_W'(1);
         r_remaining <= r_remaining - (ADDR_W + 1)'(1);
      end
   end

   // Reads issued but not yet returned; issue and return together cancel
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_inflight <= '0;
      end else begin
         case ({w_issue, w_ret})
            2'b10:   r_inflight <= r_inflight + CNT_W'(1);
            2'b01:   r_inflight <= r_inflight - CNT_W'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   // Tag pipeline travelling with each read so the returning word knows
   // whether it is valid and whether it closes the frame
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_tag_valid <= '0;
         r_tag_last  <= '0;
      end else begin
         r_tag_valid[0] <= w_issue;
         r_tag_last[0]  <= w_issue && (r_remaining == (ADDR_W + 1)'(1));
         for (int i = 1; i < RD_LAT; i++) begin
            r_tag_valid[i] <= r_tag_valid[i-1];
            r_tag_last[i]  <= r_tag_last[i-1];
         end
      end
   end

   rd_out_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_out_fifo (
      .clk         (clk),
      .rst_n       (w_rst_n),
      .i_push      (w_ret),
      .i_push_data ({r_tag_last[RD_LAT-1], ram_rdata}),
      .i_pop       (w_pop),
      .o_pop_data  (w_fifo_dout),
      .o_empty     (w_fifo_empty),
      .o_count     (w_fifo_count)
   );

   assign idle        = (r_state == ST_IDLE);
   assign ram_rd_en   = w_issue;
   assign ram_addr    = r_addr;
   assign axis_tvalid = !w_fifo_empty;
   assign axis_tdata  = w_fifo_dout[DATA_W-1:0];
   assign axis_tlast  = w_fifo_dout[DATA_W] && !w_fifo_empty;

endmodule

// File: tb/tb_ram_reader.sv
// Directed bench for ram_reader with a two-cycle-latency RAM model.
module tb_ram_reader;
   localparam int DW = 32;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          resetn = 1'b1;
   logic          start = 1'b0;
   logic [AW:0]   beat_count = '0;
   logic          idle;
   logic          ram_rd_en;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_rdata;
   logic [DW-1:0] axis_tdata;
   logic          axis_tvalid;
   logic          axis_tlast;
   logic          axis_tready = 1'b1;

   int n_vec  = 0;
   int n_miss = 0;

   logic [DW-1:0] dq[$];
   bit            lq[$];
   int            rd_q[$];
   int            outstanding = 0;
   int            stall_err = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;
   logic [DW-1:0] r_pipe0 = '0;
   logic [DW-1:0] r_pipe1 = '0;

   ram_reader #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .FIFO_DEPTH(4)) dut (
      .clk(clk), .resetn(resetn), .start(start), .beat_count(beat_count),
      .idle(idle), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
      .axis_tdata(axis_tdata), .axis_tvalid(axis_tvalid), .axis_tlast(axis_tlast),
      .axis_tready(axis_tready)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] word_at(input int a);
      return 32'hA5C3_0000 + 32'(a) * 32'h0000_0111;
   endfunction

   // RAM model: data appears two cycles after the read enable
   assign ram_rdata = r_pipe1;
   always @(posedge clk) begin
      r_pipe0 <= ram_rd_en ? word_at(int'(ram_addr)) : 32'hDEAD_BEEF;
      r_pipe1 <= r_pipe0;
   end

   // Monitor: log issued addresses, accepted beats, occupancy and stall stability
   always @(posedge clk) begin
      if (!resetn) begin
         outstanding <= 0;
         prev_stall  <= 1'b0;
      end else begin
         if (ram_rd_en) rd_q.push_back(int'(ram_addr));
         if (axis_tvalid && axis_tready) begin
            dq.push_back(axis_tdata);
            lq.push_back(axis_tlast);
         end
         outstanding <= outstanding + (ram_rd_en ? 1 : 0) - ((axis_tvalid && axis_tready) ? 1 : 0);
         if (prev_stall && ((axis_tdata !== prev_data) || (axis_tlast !== prev_last)))
            stall_err <= stall_err + 1;
         prev_stall <= axis_tvalid && !axis_tready;
         prev_data  <= axis_tdata;
         prev_last  <= axis_tlast;
      end
   end

   // Runs one frame; rnd selects 30% tready, restart_k pulses a second start at that cycle
   task automatic run_frame(input int n, input bit rnd, input int restart_k,
                            output int lat, output int last_k, output int idle_k,
                            output int maxo, output bit tmo);
      int  k;
      bit  seen_last;
      @(negedge clk);
      start = 1'b1;
      beat_count = (AW + 1)'(n);
      axis_tready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0; lat = -1; last_k = -1; idle_k = -1; maxo = 0; seen_last = 0; tmo = 0;
      while (k < 400) begin
         axis_tready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
         #1;
         if (lat < 0 && axis_tvalid) lat = k;
         if (outstanding > maxo) maxo = outstanding;
         if (seen_last && idle) begin
            idle_k = k;
            break;
         end
         if (axis_tvalid && axis_tready && axis_tlast) begin
            last_k = k;
            seen_last = 1;
         end
         if (k == restart_k) begin
            start = 1'b1;
            beat_count = (AW + 1)'(5);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      axis_tready = 1'b1;
      if (idle_k < 0) tmo = 1;
   endtask

   task automatic test_reset();
      #2 resetn = 1'b0;
      #1;
      n_vec++; if (idle !== 1'b1) begin n_miss++; $display("FAIL reset_idle: got %b want 1", idle); end
      n_vec++; if (ram_rd_en !== 1'b0) begin n_miss++; $display("FAIL reset_rd_en: got %b want 0", ram_rd_en); end
      n_vec++; if (ram_addr !== '0) begin n_miss++; $display("FAIL reset_addr: got %0d want 0", ram_addr); end
      n_vec++; if (axis_tvalid !== 1'b0) begin n_miss++; $display("FAIL reset_tvalid: got %b want 0", axis_tvalid); end
      n_vec++; if (axis_tlast !== 1'b0) begin n_miss++; $display("FAIL reset_tlast: got %b want 0", axis_tlast); end
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (4) @(negedge clk);
      n_vec++; if (idle !== 1'b1) begin n_miss++; $display("FAIL reset_release_idle: got %b want 1", idle); end
      $display("reset: checked");
   endtask

   task automatic test_basic();
      int b, rb, lat, last_k, idle_k, maxo, nlast;
      bit tmo;
      logic [DW-1:0] got;
      b = dq.size(); rb = rd_q.size();
      run_frame(8, 1'b0, -1, lat, last_k, idle_k, maxo, tmo);
      n_vec++; if (tmo) begin n_miss++; $display("FAIL basic_timeout: got timeout want idle"); end
      n_vec++; if (lat !== 3) begin n_miss++; $display("FAIL basic_latency: got %0d want 3", lat); end
      n_vec++; if (dq.size() - b !== 8) begin n_miss++; $display("FAIL basic_beats: got %0d want 8", dq.size() - b); end
      n_vec++; if (rd_q.size() - rb !== 8) begin n_miss++; $display("FAIL basic_reads: got %0d want 8", rd_q.size() - rb); end
      nlast = 0;
      for (int i = 0; i < 8; i++) begin
         got = (b + i < dq.size()) ? dq[b + i] : 'x;
         n_vec++; if (got !== word_at(i)) begin n_miss++; $display("FAIL basic_data[%0d]: got %h want %h", i, got, word_at(i)); end
         if (rb + i < rd_q.size()) begin
            n_vec++; if (rd_q[rb + i] !== i) begin n_miss++; $display("FAIL basic_addr[%0d]: got %0d want %0d", i, rd_q[rb + i], i); end
         end
         if (b + i < lq.size()) nlast += lq[b + i] ? 1 : 0;
      end
      n_vec++; if (nlast !== 1 || (b + 7 < lq.size() && !lq[b + 7])) begin n_miss++; $display("FAIL basic_tlast: got %0d tlast beats want 1 on beat 8", nlast); end
      n_vec++; if (idle_k - last_k !== 1) begin n_miss++; $display("FAIL basic_idle_gap: got %0d want 1", idle_k - last_k); end
      $display("basic: 8 beats, latency %0d, idle gap %0d", lat, idle_k - last_k);
   endtask

   task automatic test_zero();
      int bad_idle, bad_rd, bad_vld;
      bad_idle = 0; bad_rd = 0; bad_vld = 0;
      @(negedge clk);
      start = 1'b1; beat_count = '0;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (idle !== 1'b1) bad_idle++;
         if (ram_rd_en !== 1'b0) bad_rd++;
         if (axis_tvalid !== 1'b0) bad_vld++;
         @(negedge clk);
      end
      n_vec++; if (bad_idle !== 0) begin n_miss++; $display("FAIL zero_idle: got %0d low cycles want 0", bad_idle); end
      n_vec++; if (bad_rd !== 0) begin n_miss++; $display("FAIL zero_rd_en: got %0d read cycles want 0", bad_rd); end
      n_vec++; if (bad_vld !== 0) begin n_miss++; $display("FAIL zero_tvalid: got %0d valid cycles want 0", bad_vld); end
      $display("zero: start with beat_count 0 applied");
   endtask

   task automatic test_backpressure();
      int b, rb, lat, last_k, idle_k, maxo, nlast, s0;
      bit tmo;
      logic [DW-1:0] got;
      b = dq.size(); rb = rd_q.size(); s0 = stall_err;
      run_frame(16, 1'b1, -1, lat, last_k, idle_k, maxo, tmo);
      n_vec++; if (tmo) begin n_miss++; $display("FAIL bp_timeout: got timeout want idle"); end
      n_vec++; if (dq.size() - b !== 16) begin n_miss++; $display("FAIL bp_beats: got %0d want 16", dq.size() - b); end
      n_vec++; if (rd_q.size() - rb !== 16) begin n_miss++; $display("FAIL bp_reads: got %0d want 16", rd_q.size() - rb); end
      nlast = 0;
      for (int i = 0; i < 16; i++) begin
         got = (b + i < dq.size()) ? dq[b + i] : 'x;
         n_vec++; if (got !== word_at(i)) begin n_miss++; $display("FAIL bp_data[%0d]: got %h want %h", i, got, word_at(i)); end
         if (rb + i < rd_q.size()) begin
            n_vec++; if (rd_q[rb + i] !== i) begin n_miss++; $display("FAIL bp_addr[%0d]: got %0d want %0d", i, rd_q[rb + i], i); end
         end
         if (b + i < lq.size()) nlast += lq[b + i] ? 1 : 0;
      end
      n_vec++; if (nlast !== 1 || (b + 15 < lq.size() && !lq[b + 15])) begin n_miss++; $display("FAIL bp_tlast: got %0d tlast beats want 1 on beat 16", nlast); end
      n_vec++; if (stall_err - s0 !== 0) begin n_miss++; $display("FAIL bp_stall_stable: got %0d changes want 0", stall_err - s0); end
      n_vec++; if (maxo > 4) begin n_miss++; $display("FAIL bp_occupancy: got %0d want <= 4", maxo); end
      n_vec++; if (ram_addr !== '0) begin n_miss++; $display("FAIL bp_addr_wrap: got %0d want 0", ram_addr); end
      n_vec++; if (idle_k - last_k !== 1) begin n_miss++; $display("FAIL bp_idle_gap: got %0d want 1", idle_k - last_k); end
      $display("backpressure: 16 beats, peak occupancy %0d", maxo);
   endtask

   task automatic test_restart_ignored();
      int b, rb, lat, last_k, idle_k, maxo, nlast;
      bit tmo;
      logic [DW-1:0] got;
      b = dq.size(); rb = rd_q.size();
      run_frame(8, 1'b0, 3, lat, last_k, idle_k, maxo, tmo);
      n_vec++; if (tmo) begin n_miss++; $display("FAIL restart_timeout: got timeout want idle"); end
      n_vec++; if (dq.size() - b !== 8) begin n_miss++; $display("FAIL restart_beats: got %0d want 8", dq.size() - b); end
      n_vec++; if (rd_q.size() - rb !== 8) begin n_miss++; $display("FAIL restart_reads: got %0d want 8", rd_q.size() - rb); end
      nlast = 0;
      for (int i = 0; i < 8; i++) begin
         got = (b + i < dq.size()) ? dq[b + i] : 'x;
         n_vec++; if (got !== word_at(i)) begin n_miss++; $display("FAIL restart_data[%0d]: got %h want %h", i, got, word_at(i)); end
         if (b + i < lq.size()) nlast += lq[b + i] ? 1 : 0;
      end
      n_vec++; if (nlast !== 1) begin n_miss++; $display("FAIL restart_tlast: got %0d tlast beats want 1", nlast); end
      $display("restart: second start during frame applied");
   endtask

   task automatic test_reset_midframe();
      int b, rb, k, lat, last_k, idle_k, maxo;
      bit tmo;
      logic [DW-1:0] got;
      b = dq.size();
      @(negedge clk);
      start = 1'b1; beat_count = (AW + 1)'(10); axis_tready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while ((dq.size() - b < 3) && (k < 50)) begin
         @(negedge clk);
         k++;
      end
      n_vec++; if (dq.size() - b !== 3) begin n_miss++; $display("FAIL mid_pre_beats: got %0d want 3", dq.size() - b); end
      resetn = 1'b0;
      #1;
      n_vec++; if (idle !== 1'b1) begin n_miss++; $display("FAIL mid_idle: got %b want 1", idle); end
      n_vec++; if (axis_tvalid !== 1'b0) begin n_miss++; $display("FAIL mid_tvalid: got %b want 0", axis_tvalid); end
      n_vec++; if (ram_rd_en !== 1'b0) begin n_miss++; $display("FAIL mid_rd_en: got %b want 0", ram_rd_en); end
      n_vec++; if (ram_addr !== '0) begin n_miss++; $display("FAIL mid_addr: got %0d want 0", ram_addr); end
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      b = dq.size();
      repeat (20) @(negedge clk);
      n_vec++; if (dq.size() - b !== 0) begin n_miss++; $display("FAIL mid_stale_beats: got %0d want 0", dq.size() - b); end
      n_vec++; if (idle !== 1'b1) begin n_miss++; $display("FAIL mid_post_idle: got %b want 1", idle); end
      b = dq.size(); rb = rd_q.size();
      run_frame(4, 1'b0, -1, lat, last_k, idle_k, maxo, tmo);
      n_vec++; if (tmo) begin n_miss++; $display("FAIL mid_new_timeout: got timeout want idle"); end
      n_vec++; if (dq.size() - b !== 4) begin n_miss++; $display("FAIL mid_new_beats: got %0d want 4", dq.size() - b); end
      for (int i = 0; i < 4; i++) begin
         got = (b + i < dq.size()) ? dq[b + i] : 'x;
         n_vec++; if (got !== word_at(i)) begin n_miss++; $display("FAIL mid_new_data[%0d]: got %h want %h", i, got, word_at(i)); end
         if (rb + i < rd_q.size()) begin
            n_vec++; if (rd_q[rb + i] !== i) begin n_miss++; $display("FAIL mid_new_addr[%0d]: got %0d want %0d", i, rd_q[rb + i], i); end
         end
      end
      n_vec++; if (b + 3 >= lq.size() || !lq[b + 3]) begin n_miss++; $display("FAIL mid_new_tlast: got no tlast on beat 4 want tlast"); end
      $display("reset_midframe: reset after 3 beats, then 4-beat frame");
   endtask

   task automatic test_single();
      int b, rb, lat, last_k, idle_k, maxo;
      bit tmo;
      logic [DW-1:0] got;
      b = dq.size(); rb = rd_q.size();
      run_frame(1, 1'b0, -1, lat, last_k, idle_k, maxo, tmo);
      n_vec++; if (tmo) begin n_miss++; $display("FAIL single_timeout: got timeout want idle"); end
      n_vec++; if (dq.size() - b !== 1) begin n_miss++; $display("FAIL single_beats: got %0d want 1", dq.size() - b); end
      n_vec++; if (rd_q.size() - rb !== 1 || (rb < rd_q.size() && rd_q[rb] !== 0)) begin n_miss++; $display("FAIL single_reads: got %0d reads want 1 at addr 0", rd_q.size() - rb); end
      got = (b < dq.size()) ? dq[b] : 'x;
      n_vec++; if (got !== word_at(0)) begin n_miss++; $display("FAIL single_data: got %h want %h", got, word_at(0)); end
      n_vec++; if (b >= lq.size() || !lq[b]) begin n_miss++; $display("FAIL single_tlast: got 0 want 1"); end
      n_vec++; if (idle_k - last_k !== 1) begin n_miss++; $display("FAIL single_idle_gap: got %0d want 1", idle_k - last_k); end
      $display("single: 1-beat frame, latency %0d", lat);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_backpressure();
      test_restart_ignored();
      test_reset_midframe();
      test_single();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running want finished");
      $fatal(1, "time limit");
   end

endmodule
